sample_iterator: RTL and testbench

- Generates sample positions for one triangle at a time and drives the sample-test stage that consumes them.
- Accepts a triangle, its color, its grid-aligned bounding box and the MSAA mode from the bounding-box stage.
- Walks the box in raster order, emitting SAMPS horizontally adjacent samples per cycle.
- Stalls upstream through an active-low halt while a triangle is in flight.

---
 rtl/rast_pkg.sv | 27 ++
 rtl/sample_lane_gen.sv | 42 ++++
 rtl/sample_iterator.sv | 154 +++++++++++++++
 tb/tb_sample_iterator.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/rast_pkg.sv
// rtl/rast_pkg.sv - shared rasterizer types, MSAA mode encodings and box indices
package rast_pkg;

  typedef enum logic {
    WAIT = 1'b0,
    TEST = 1'b1
  } state_t;

  localparam logic [3:0] MSAA_1X  = 4'b1000;
  localparam logic [3:0] MSAA_4X  = 4'b0100;
  localparam logic [3:0] MSAA_16X = 4'b0010;
  localparam logic [3:0] MSAA_64X = 4'b0001;

  localparam int LL = 0;
  localparam int UR = 1;

  // Anything that is not a clean one-hot code falls back to 1x spacing.
  function automatic int step_from_mode(input logic [3:0] mode, input int radix);
    case (mode)
      MSAA_4X:  return 1 << (radix - 1);
      MSAA_16X: return 1 << (radix - 2);
      MSAA_64X: return 1 << (radix - 3);
      default:  return 1 << radix;
    endcase
  endfunction

endpackage

// File: rtl/sample_lane_gen.sv
// rtl/sample_lane_gen.sv - lane x positions, valid bits and row/box end flags for one sample group
module sample_lane_gen #(
  parameter int SIGFIG = 24,
  parameter int SAMPS  = 4
) (
  input  logic signed [SIGFIG:0]   i_cur_x,
  input  logic signed [SIGFIG:0]   i_cur_y,
  input  logic signed [SIGFIG:0]   i_step,
  input  logic signed [SIGFIG:0]   i_ur_x,
  input  logic signed [SIGFIG:0]   i_ur_y,
  output logic signed [SIGFIG-1:0] o_lane_x [SAMPS],
  output logic [SAMPS-1:0]         o_lane_valid,
  output logic signed [SIGFIG:0]   o_next_x,
  output logic                     o_row_end,
  output logic                     o_box_end
);

  // Adder chain: entry SAMPS is where the next group in this row would start.
  logic signed [SIGFIG:0] w_x [SAMPS+1];
  logic signed [SIGFIG:0] w_next_y;

  always_comb begin
    w_x[0] = i_cur_x;
    for (int s = 1; s <= SAMPS; s++) begin
      w_x[s] = w_x[s-1] + i_step;
    end
  end

  always_comb begin
    o_lane_valid = '0;
    for (int s = 0; s < SAMPS; s++) begin
      o_lane_x[s]     = w_x[s][SIGFIG-1:0];
      o_lane_valid[s] = (w_x[s] <= i_ur_x);
    end
  end

  assign w_next_y  = i_cur_y + i_step;
  assign o_next_x  = w_x[SAMPS];
  assign o_row_end = (w_x[SAMPS] > i_ur_x);
  assign o_box_end = o_row_end && (w_next_y > i_ur_y);

endmodule

// File: rtl/sample_iterator.sv
// rtl/sample_iterator.sv - walks a triangle bounding box in raster order, SAMPS samples per cycle
module sample_iterator #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3,
  parameter int SAMPS  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R13U [COLORS],
  input  logic signed [SIGFIG-1:0] box_R13S [2][2],
  input  logic [3:0]               subSample_R13U,
  input  logic                     validTri_R13H,
  output logic                     halt_R13L,
  output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R14U [COLORS],
  output logic signed [SIGFIG-1:0] sample_R14S [2][SAMPS],
  output logic [SAMPS-1:0]         validSamp_R14H
);
  import rast_pkg::*;

  localparam int W = SIGFIG + 1;

  state_t r_state;
  state_t w_state_nxt;
  logic   w_accept;
  logic   w_load;

  logic signed [SIGFIG-1:0] r_tri [VERTS][AXIS];
  logic        [SIGFIG-1:0] r_color [COLORS];
  logic signed [SIGFIG-1:0] r_sample [2][SAMPS];
  logic [SAMPS-1:0]         r_valid;
  logic                     r_halt;

  logic signed [W-1:0] r_ll_x, r_ur_x, r_ur_y, r_step;
  logic signed [W-1:0] r_cur_y, r_next_x;
  logic                r_row_end, r_box_end;

  logic signed [W-1:0] w_in_ll_x, w_in_ll_y, w_in_ur_x, w_in_ur_y, w_in_step;
  logic signed [W-1:0] w_gen_x, w_gen_y, w_gen_step, w_gen_ur_x, w_gen_ur_y;

  logic signed [SIGFIG-1:0] w_lane_x [SAMPS];
  logic [SAMPS-1:0]         w_lane_valid;
  logic signed [W-1:0]      w_next_x;
  logic                     w_row_end, w_box_end;

  assign w_in_ll_x = W'(box_R13S[LL][0]);
  assign w_in_ll_y = W'(box_R13S[LL][1]);
  assign w_in_ur_x = W'(box_R13S[UR][0]);
  assign w_in_ur_y = W'(box_R13S[UR][1]);
  assign w_in_step = W'(step_from_mode(subSample_R13U, RADIX));

  // The lane generator always looks at the group about to be registered:
  // the box corner on acceptance, otherwise the successor of the group on display.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_gen_x     = r_row_end ? r_ll_x : r_next_x;
    w_gen_y     = r_row_end ? (r_cur_y + r_step) : r_cur_y;
    w_gen_step  = r_step;
    w_gen_ur_x  = r_ur_x;
    w_gen_ur_y  = r_ur_y;
    case (r_state)
      WAIT: begin
        w_gen_x    = w_in_ll_x;
        w_gen_y    = w_in_ll_y;
        w_gen_step = w_in_step;
        w_gen_ur_x = w_in_ur_x;
        w_gen_ur_y = w_in_ur_y;
        if (validTri_R13H) begin
          w_accept = 1'b1;
          if ((w_in_ur_x >= w_in_ll_x) && (w_in_ur_y >= w_in_ll_y)) begin
            w_state_nxt = TEST;
          end
        end
      end
      TEST: begin
        if (r_box_end) begin
          w_state_nxt = WAIT;
        end
      end
      default: w_state_nxt = WAIT;
    endcase
  end

  assign w_load = (w_state_nxt == TEST);

  sample_lane_gen #(
    .SIGFIG(SIGFIG),
    .SAMPS (SAMPS)
  ) u_lane_gen (
    .i_cur_x     (w_gen_x),
    .i_cur_y     (w_gen_y),
    .i_step      (w_gen_step),
    .i_ur_x      (w_gen_ur_x),
    .i_ur_y      (w_gen_ur_y),
    .o_lane_x    (w_lane_x),
    .o_lane_valid(w_lane_valid),
    .o_next_x    (w_next_x),
    .o_row_end   (w_row_end),
    .o_box_end   (w_box_end)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= WAIT;
      r_halt    <= 1'b1;
      r_valid   <= '0;
      r_tri     <= '{default: '0};
      r_color   <= '{default: '0};
      r_sample  <= '{default: '0};
      r_ll_x    <= '0;
      r_ur_x    <= '0;
      r_ur_y    <= '0;
      r_step    <= '0;
      r_cur_y   <= '0;
      r_next_x  <= '0;
      r_row_end <= 1'b0;
      r_box_end <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_halt  <= !w_load;
      r_valid <= w_load ? w_lane_valid : '0;
      if (w_accept) begin
        r_tri   <= tri_R13S;
        r_color <= color_R13U;
        r_ll_x  <= w_in_ll_x;
        r_ur_x  <= w_in_ur_x;
        r_ur_y  <= w_in_ur_y;
        r_step  <= w_in_step;
      end
      if (w_load) begin
        r_cur_y   <= w_gen_y;
        r_next_x  <= w_next_x;
        r_row_end <= w_row_end;
        r_box_end <= w_box_end;
        for (int s = 0; s < SAMPS; s++) begin
          r_sample[0][s] <= w_lane_x[s];
          r_sample[1][s] <= w_gen_y[SIGFIG-1:0];
        end
      end
    end
  end

  assign halt_R13L      = r_halt;
  assign validSamp_R14H = r_valid;
  assign tri_R14S       = r_tri;
  assign color_R14U     = r_color;
  assign sample_R14S    = r_sample;

endmodule

// File: tb/tb_sample_iterator.sv
// tb/tb_sample_iterator.sv - scoreboard bench for sample_iterator
module tb_sample_iterator;

  typedef struct packed {
    logic [3:0]       mask;
    logic [3:0][31:0] x;
    logic [31:0]      y;
    logic [31:0]      id;
  } grp_t;

  logic              clk;
  logic              rst;
  logic signed [23:0] tri_in [3][3];
  logic        [23:0] col_in [3];
  logic signed [23:0] box_in [2][2];
  logic [3:0]         mode_in;
  logic               valid_in;
  logic               halt_R13L;
  logic signed [23:0] tri_out [3][3];
  logic        [23:0] col_out [3];
  logic signed [23:0] samp_out [2][4];
  logic [3:0]         vsamp;

  int   n_checks = 0;
  int   n_fail   = 0;
  grp_t q[$];
  grp_t mon_g;

  sample_iterator dut (
    .clk           (clk),
    .rst           (rst),
    .tri_R13S      (tri_in),
    .color_R13U    (col_in),
    .box_R13S      (box_in),
    .subSample_R13U(mode_in),
    .validTri_R13H (valid_in),
    .halt_R13L     (halt_R13L),
    .tri_R14S      (tri_out),
    .color_R14U    (col_out),
    .sample_R14S   (samp_out),
    .validSamp_R14H(vsamp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_tri(input int llx, input int lly, input int urx, input int ury,
                         input logic [3:0] mode, input int id);
    box_in[0][0] = 24'(llx);
    box_in[0][1] = 24'(lly);
    box_in[1][0] = 24'(urx);
    box_in[1][1] = 24'(ury);
    mode_in = mode;
    for (int v = 0; v < 3; v++)
      for (int a = 0; a < 3; a++)
        tri_in[v][a] = 24'(id * 16 + v * 3 + a);
    for (int c = 0; c < 3; c++) col_in[c] = 24'(id * 100 + c);
  endtask

  task automatic model_push(input int llx, input int lly, input int urx, input int ury,
                            input logic [3:0] mode, input int id);
    int   st;
    grp_t g;
    case (mode)
      4'b0100: st = 512;
      4'b0010: st = 256;
      4'b0001: st = 128;
      default: st = 1024;
    endcase
    for (int y = lly; y <= ury; y += st) begin
      for (int x = llx; x <= urx; x += 4 * st) begin
        for (int s = 0; s < 4; s++) begin
          g.x[s]    = 32'(x + s * st);
          g.mask[s] = (x + s * st <= urx);
        end
        g.y  = 32'(y);
        g.id = 32'(id);
        q.push_back(g);
      end
    end
  endtask

  task automatic send_tri(input int llx, input int lly, input int urx, input int ury,
                          input logic [3:0] mode, input int id);
    int guard = 0;
    while (halt_R13L !== 1'b1 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("accept_ready", {63'd0, halt_R13L}, 64'd1);
    set_tri(llx, lly, urx, ury, mode, id);
    model_push(llx, lly, urx, ury, mode, id);
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic drain(input string tag);
    int guard = 0;
    while ((q.size() != 0 || halt_R13L !== 1'b1) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    repeat (2) @(negedge clk);
    check(tag, 64'(q.size()), 64'd0);
  endtask

  always @(negedge clk) begin
    if (rst && vsamp != 4'd0) begin
      if (q.size() == 0) begin
        check("unexpected_group", {60'd0, vsamp}, 64'd0);
      end else begin
        mon_g = q.pop_front();
        check("lane_mask", {60'd0, vsamp}, {60'd0, mon_g.mask});
        for (int s = 0; s < 4; s++)
          check($sformatf("lane_x%0d", s), {40'd0, samp_out[0][s]}, {40'd0, mon_g.x[s][23:0]});
        check("lane_y", {40'd0, samp_out[1][3]}, {40'd0, mon_g.y[23:0]});
        check("tri00", {40'd0, tri_out[0][0]}, 64'(mon_g.id * 16));
        check("tri22", {40'd0, tri_out[2][2]}, 64'(mon_g.id * 16 + 8));
        check("color2", {40'd0, col_out[2]}, 64'(mon_g.id * 100 + 2));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int c;
    rst      = 1'b0;
    valid_in = 1'b0;
    set_tri(0, 0, 0, 0, 4'b1000, 0);
    #12;
    check("rst_halt", {63'd0, halt_R13L}, 64'd1);
    check("rst_valid", {60'd0, vsamp}, 64'd0);
    check("rst_sample", {40'd0, samp_out[0][1]}, 64'd0);
    check("rst_tri", {40'd0, tri_out[1][1]}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // 1x two-row box; halt low exactly two cycles
    send_tri(0, 0, 3072, 1024, 4'b1000, 1);
    c = 0;
    while (halt_R13L == 1'b0 && c < 50) begin
      c++;
      @(negedge clk);
    end
    check("t1_halt_low_cycles", 64'(c), 64'd2);
    drain("t1_drain");

    send_tri(0, 0, 4096, 0, 4'b1000, 2);
    drain("t2_drain");

    send_tri(512, 512, 1024, 1024, 4'b0100, 3);
    drain("t3_drain");

    // inverted box is dropped
    send_tri(2048, 0, 1024, 0, 4'b1000, 4);
    for (int i = 0; i < 3; i++) begin
      check("t4_halt_high", {63'd0, halt_R13L}, 64'd1);
      check("t4_no_valid", {60'd0, vsamp}, 64'd0);
      @(negedge clk);
    end
    send_tri(0, 0, 256, 256, 4'b0010, 5);
    drain("t4_next_drain");

    send_tri(0, 0, 1024, 0, 4'b0110, 7);
    drain("nonhot_drain");
    send_tri(-2048, -1024, -1024, -1024, 4'b1000, 8);
    drain("neg_drain");
    send_tri(8387584, 8387584, 8387584, 8387584, 4'b1000, 9);
    drain("max_drain");
    send_tri(128, 0, 128, 128, 4'b0001, 10);
    drain("x64_drain");

    // B held valid during A's TEST, with a different mode
    send_tri(0, 0, 3072, 1024, 4'b1000, 11);
    set_tri(0, 0, 512, 0, 4'b0100, 12);
    model_push(0, 0, 512, 0, 4'b0100, 12);
    valid_in = 1'b1;
    c = 0;
    while (halt_R13L !== 1'b1 && c < 50) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    valid_in = 1'b0;
    drain("t6_drain");

    // async reset in the first TEST cycle
    set_tri(0, 0, 3072, 1024, 4'b1000, 13);
    valid_in = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    valid_in = 1'b0;
    check("t5_valid_clr", {60'd0, vsamp}, 64'd0);
    check("t5_halt_set", {63'd0, halt_R13L}, 64'd1);
    check("t5_sample_clr", {40'd0, samp_out[0][1]}, 64'd0);
    check("t5_tri_clr", {40'd0, tri_out[0][0]}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_quiet", {60'd0, vsamp}, 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
